// File: rtl/mem_arbiter.sv
// Two-requester (CPU / host) arbiter and wait-state sequencer for the single-port main memory.
// Optional access statistics are compiled in with the ARB_STATS_EN macro.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 8,
  parameter int WAIT      = 1,
  parameter int HOST_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ready,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic [DW-1:0] host_rdata,
  output logic          host_ready,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_read,
  output logic          mem_write,
  output logic [1:0]    grant,
`ifdef ARB_STATS_EN
  output logic [15:0]   cpu_cnt,
  output logic [15:0]   host_cnt,
  output logic [15:0]   conflict_cnt,
`endif
  output logic          busy
);

  if (WAIT < 32'sd1 || WAIT > 32'sd7) begin : g_wait_check
    $error("mem_arbiter: WAIT=%0d is outside the legal range 1..7", WAIT);
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [2:0] WAIT_M1 = 3'(WAIT - 1);

  state_t        state_r, state_s;
  logic [2:0]    cnt_r, cnt_s;
  logic          we_r, we_s;
  logic          last_host_r, last_host_s;
  logic          win_host_s;
  logic [AW-1:0] mem_addr_s;
  logic [DW-1:0] mem_wdata_s, cpu_rdata_s, host_rdata_s;
  logic          mem_read_s, mem_write_s, cpu_ready_s, host_ready_s, busy_s;
  logic [1:0]    grant_s;

  // Arbitration winner: host on fixed priority, otherwise whoever did not win last time
  always_comb begin
    win_host_s = 1'b0;
    if (cpu_req && host_req) begin
      win_host_s = (HOST_PRIO != 32'sd0) ? 1'b1 : ~last_host_r;
    end else begin
      win_host_s = host_req;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (cpu_req || host_req) begin
          state_s = S_ACCESS;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (cnt_r == 3'd0) begin
          state_s = S_DONE;
        end else begin
          state_s = S_ACCESS;
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Output logic: next values of every registered output and of the access context
  always_comb begin
    mem_addr_s   = mem_addr;
    mem_wdata_s  = mem_wdata;
    cpu_rdata_s  = cpu_rdata;
    host_rdata_s = host_rdata;
    we_s         = we_r;
    last_host_s  = last_host_r;
    cnt_s        = cnt_r;
    grant_s      = grant;
    busy_s       = busy;
    mem_read_s   = mem_read;
    mem_write_s  = mem_write;
    cpu_ready_s  = 1'b0;
    host_ready_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (cpu_req || host_req) begin
          if (win_host_s) begin
            mem_addr_s  = host_addr;
            mem_wdata_s = host_wdata;
            we_s        = host_we;
            grant_s     = 2'b10;
          end else begin
            mem_addr_s  = cpu_addr;
            mem_wdata_s = cpu_wdata;
            we_s        = cpu_we;
            grant_s     = 2'b01;
          end
          last_host_s = win_host_s;
          cnt_s       = WAIT_M1;
          busy_s      = 1'b1;
          mem_read_s  = ~we_s;
          mem_write_s = we_s;
        end else begin
          grant_s     = 2'b00;
          busy_s      = 1'b0;
          mem_read_s  = 1'b0;
          mem_write_s = 1'b0;
        end
      end
      S_ACCESS: begin
        if (cnt_r == 3'd0) begin
          mem_read_s  = 1'b0;
          mem_write_s = 1'b0;
          // Read data is taken on the last strobed cycle; writes leave rdata alone
          if (grant[1]) begin
            host_ready_s = 1'b1;
            if (!we_r) begin
              host_rdata_s = mem_rdata;
            end else begin
              host_rdata_s = host_rdata;
            end
          end else begin
            cpu_ready_s = 1'b1;
            if (!we_r) begin
              cpu_rdata_s = mem_rdata;
            end else begin
              cpu_rdata_s = cpu_rdata;
            end
          end
        end else begin
          cnt_s = cnt_r - 3'd1;
        end
      end
      S_DONE: begin
        grant_s = 2'b00;
        busy_s  = 1'b0;
      end
      default: begin
        grant_s     = 2'b00;
        busy_s      = 1'b0;
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
      end
    endcase
  end

  // Output and access-context registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cpu_rdata   <= '0;
      host_rdata  <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      cpu_ready   <= 1'b0;
      host_ready  <= 1'b0;
      grant       <= 2'b00;
      busy        <= 1'b0;
      we_r        <= 1'b0;
      cnt_r       <= 3'd0;
      last_host_r <= 1'b1;
    end else begin
      mem_addr    <= mem_addr_s;
      mem_wdata   <= mem_wdata_s;
      cpu_rdata   <= cpu_rdata_s;
      host_rdata  <= host_rdata_s;
      mem_read    <= mem_read_s;
      mem_write   <= mem_write_s;
      cpu_ready   <= cpu_ready_s;
      host_ready  <= host_ready_s;
      grant       <= grant_s;
      busy        <= busy_s;
      we_r        <= we_s;
      cnt_r       <= cnt_s;
      last_host_r <= last_host_s;
    end
  end

`ifdef ARB_STATS_EN
  // Saturating completion and conflict counters
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_cnt      <= 16'd0;
      host_cnt     <= 16'd0;
      conflict_cnt <= 16'd0;
    end else begin
      if (state_r == S_DONE && grant[0] && cpu_cnt != 16'hFFFF) begin
        cpu_cnt <= cpu_cnt + 16'd1;
      end
      if (state_r == S_DONE && grant[1] && host_cnt != 16'hFFFF) begin
        host_cnt <= host_cnt + 16'd1;
      end
      if (state_r == S_IDLE && cpu_req && host_req && conflict_cnt != 16'hFFFF) begin
        conflict_cnt <= conflict_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
